// File: rtl/morse_pkg.sv
// Shared Morse symbol codes, ASCII constants and consumer FSM encoding.
// The producer side of the link uses the same symbol codes.
package morse_pkg;

    localparam logic [1:0] SYM_EMPTY = 2'b00;
    localparam logic [1:0] SYM_DOT   = 2'b01;
    localparam logic [1:0] SYM_DASH  = 2'b10;
    localparam logic [1:0] SYM_ILL   = 2'b11;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_DECODE  = 3'd2,
        ST_PUSH    = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    // Builds a frame with symbol s0 in the lowest bit pair (sent first).
    function automatic logic [9:0] frame5(input logic [1:0] s0, input logic [1:0] s1,
                                          input logic [1:0] s2, input logic [1:0] s3,
                                          input logic [1:0] s4);
        return {s4, s3, s2, s1, s0};
    endfunction

endpackage

// File: rtl/morse_char_lut.sv
// Combinational frame-to-ASCII lookup for ITU Morse letters and digits.
// Only well-formed patterns appear in the table, so illegal symbols and gaps fall to '?'.
module morse_char_lut
    import morse_pkg::*;
(
    input  logic [9:0] inbits,
    output logic       valid_char,
    output logic       is_gap,
    output logic [7:0] ascii
);

    localparam logic [1:0] NO = SYM_EMPTY;
    localparam logic [1:0] DI = SYM_DOT;
    localparam logic [1:0] DA = SYM_DASH;

    always_comb begin
        valid_char = 1'b1;
        is_gap     = 1'b0;
        ascii      = ASCII_UNKNOWN;
        case (inbits)
            frame5(NO, NO, NO, NO, NO): begin
                valid_char = 1'b0;
                is_gap     = 1'b1;
                ascii      = ASCII_SPACE;
            end
            frame5(DI, DA, NO, NO, NO): ascii = "A";
            frame5(DA, DI, DI, DI, NO): ascii = "B";
            frame5(DA, DI, DA, DI, NO): ascii = "C";
            frame5(DA, DI, DI, NO, NO): ascii = "D";
            frame5(DI, NO, NO, NO, NO): ascii = "E";
            frame5(DI, DI, DA, DI, NO): ascii = "F";
            frame5(DA, DA, DI, NO, NO): ascii = "G";
            frame5(DI, DI, DI, DI, NO): ascii = "H";
            frame5(DI, DI, NO, NO, NO): ascii = "I";
            frame5(DI, DA, DA, DA, NO): ascii = "J";
            frame5(DA, DI, DA, NO, NO): ascii = "K";
            frame5(DI, DA, DI, DI, NO): ascii = "L";
            frame5(DA, DA, NO, NO, NO): ascii = "M";
            frame5(DA, DI, NO, NO, NO): ascii = "N";
            frame5(DA, DA, DA, NO, NO): ascii = "O";
            frame5(DI, DA, DA, DI, NO): ascii = "P";
            frame5(DA, DA, DI, DA, NO): ascii = "Q";
            frame5(DI, DA, DI, NO, NO): ascii = "R";
            frame5(DI, DI, DI, NO, NO): ascii = "S";
            frame5(DA, NO, NO, NO, NO): ascii = "T";
            frame5(DI, DI, DA, NO, NO): ascii = "U";
            frame5(DI, DI, DI, DA, NO): ascii = "V";
            frame5(DI, DA, DA, NO, NO): ascii = "W";
            frame5(DA, DI, DI, DA, NO): ascii = "X";
            frame5(DA, DI, DA, DA, NO): ascii = "Y";
            frame5(DA, DA, DI, DI, NO): ascii = "Z";
            frame5(DA, DA, DA, DA, DA): ascii = "0";
            frame5(DI, DA, DA, DA, DA): ascii = "1";
            frame5(DI, DI, DA, DA, DA): ascii = "2";
            frame5(DI, DI, DI, DA, DA): ascii = "3";
            frame5(DI, DI, DI, DI, DA): ascii = "4";
            frame5(DI, DI, DI, DI, DI): ascii = "5";
            frame5(DA, DI, DI, DI, DI): ascii = "6";
            frame5(DA, DA, DI, DI, DI): ascii = "7";
            frame5(DA, DA, DA, DI, DI): ascii = "8";
            frame5(DA, DA, DA, DA, DI): ascii = "9";
            default:                    valid_char = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_sequence_consumer.sv
// Receives Morse frames from the producer, decodes each into ASCII and queues it
// in a first-word-fall-through FIFO; flags end-of-message and dropped characters.
module morse_sequence_consumer
    import morse_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic [9:0]             inbits,
    input  logic                   spa_end,
    input  logic                   sent,
    input  logic                   Clear,
    input  logic                   char_ready,
    output logic [7:0]             char_out,
    output logic                   char_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   msg_done,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [SYNC_STAGES-1:0] sent_sync_reg;
    logic [SYNC_STAGES-1:0] spa_sync_reg;
    logic                   sent_prev_reg;
    logic                   edge_det;

    state_t                 state_reg, state_next;
    logic                   capture_en, push_req, set_done;

    logic [9:0]             frame_reg;
    logic                   spa_reg;
    logic                   msg_done_reg, overflow_reg;
    logic [AW:0]            wr_ptr_reg, rd_ptr_reg;
    logic [7:0]             mem [DEPTH];

    logic                   lut_valid, lut_gap;
    logic [7:0]             lut_ascii, push_data;
    logic                   full, do_push, do_pop;

    // Synchronisers are deliberately untouched by Clear so no false edge follows it.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sent_sync_reg <= '0;
            spa_sync_reg  <= '0;
            sent_prev_reg <= 1'b0;
        end else begin
            sent_sync_reg[0] <= sent;
            spa_sync_reg[0]  <= spa_end;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sent_sync_reg[i] <= sent_sync_reg[i-1];
                spa_sync_reg[i]  <= spa_sync_reg[i-1];
            end
            sent_prev_reg <= sent_sync_reg[SYNC_STAGES-1];
        end
    end

    assign edge_det = sent_sync_reg[SYNC_STAGES-1] & ~sent_prev_reg;

    morse_char_lut u_lut (
        .inbits     (frame_reg),
        .valid_char (lut_valid),
        .is_gap     (lut_gap),
        .ascii      (lut_ascii)
    );

    assign push_data = (lut_valid || lut_gap) ? lut_ascii : ASCII_UNKNOWN;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)
            state_reg <= ST_IDLE;
        else if (Clear)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (edge_det) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_DECODE;
            // An empty EndSeq frame carries no character, only the end-of-message mark.
            ST_DECODE:  state_next = (lut_gap && spa_reg) ? ST_FINISH : ST_PUSH;
            ST_PUSH:    state_next = ST_FINISH;
            ST_FINISH:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        capture_en = (state_reg == ST_CAPTURE);
        push_req   = (state_reg == ST_PUSH);
        set_done   = (state_reg == ST_FINISH) && spa_reg;
    end

    assign char_valid = (wr_ptr_reg != rd_ptr_reg);
    assign full       = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}});
    assign do_pop     = char_valid && char_ready && !Clear;
    assign do_push    = push_req && !Clear && (!full || do_pop);
    assign count      = wr_ptr_reg - rd_ptr_reg;
    assign char_out   = char_valid ? mem[rd_ptr_reg[AW-1:0]] : 8'h00;
    assign msg_done   = msg_done_reg;
    assign overflow   = overflow_reg;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            frame_reg    <= '0;
            spa_reg      <= 1'b0;
            msg_done_reg <= 1'b0;
            overflow_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else if (Clear) begin
            msg_done_reg <= 1'b0;
            overflow_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            if (capture_en) begin
                frame_reg    <= inbits;
                spa_reg      <= spa_sync_reg[SYNC_STAGES-1];
                msg_done_reg <= 1'b0;
            end
            if (set_done)
                msg_done_reg <= 1'b1;
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            if (push_req && full && !do_pop)
                overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: doc/morse_sequence_consumer.md
# morse_sequence_consumer

Receiving end of the Morse link. Accepts the 10-bit symbol frame, the space/end flag and the `sent` strobe emitted by the sequence producer, synchronises them into the local clock domain, and decodes each frame into one ASCII character. Characters go into a small FIFO for a display or UART stage, and the block flags end-of-message.

## Interface
- `DEPTH`, 16: character FIFO depth (power of two, ≥2).
- `SYNC_STAGES`, 2: flip-flop stages on `sent` and `spa_end`.
- `clk`  in  1  system clock; every flop in the block runs on it.
- `Reset`  in  1  asynchronous, active-low reset.
- `inbits`  in  10  symbol frame. Symbol k occupies bits [2k+1:2k], k=0 first. Codes: 00 empty, 01 dot, 10 dash, 11 illegal.
- `spa_end`  in  1  frame terminator: 0 = Space (letter end), 1 = EndSeq (message end).
- `sent`  in  1  frame-valid level from the producer. The producer holds `inbits`/`spa_end` stable while it is high.
- `Clear`  in  1  synchronous flush: empties FIFO, clears flags.
- `char_ready`  in  1  downstream accepts `char_out`.
- `char_out`  out  8  ASCII at FIFO head.
- `char_valid`  out  1  FIFO non-empty.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `msg_done`  out  1  sticky: an EndSeq frame has been fully processed.
- `overflow`  out  1  sticky: a character was dropped because the FIFO was full.

## Operation
- `sent` passes through SYNC_STAGES flops. A rising edge on the synchronised version starts capture. `inbits` is sampled raw in that cycle; it is stable by producer guarantee.
- FSM states:
  - IDLE: on edge → CAPTURE.
  - CAPTURE: latch frame and `spa_end`; clear `msg_done` → DECODE.
  - DECODE: look up the character → PUSH, or → FINISH if nothing is to be pushed.
  - PUSH: write to the FIFO → FINISH.
  - FINISH: if `spa_end`=1, set `msg_done` → IDLE.
- Decode rules:
  - Symbols are read from k=0 up to the first 00. Pattern length is 0 to 5.
  - Any 11 symbol, or any non-empty symbol after an empty one, gives '?' (0x3F).
  - Length 1–5 patterns map to A–Z (0x41–0x5A) and 0–9 (0x30–0x39) per ITU Morse. Any unmapped pattern gives '?'.
  - Length 0 with `spa_end`=0 pushes ' ' (0x20), the word gap.
  - Length 0 with `spa_end`=1 pushes nothing; it only sets `msg_done`.
- FIFO is first-word-fall-through. Pop happens when `char_valid && char_ready`.
- Push when full:
  - Without a same-cycle pop, the push is dropped and `overflow` is set.
  - With a same-cycle pop, both happen and occupancy is unchanged.
- A `sent` edge while the FSM is not IDLE is ignored (the producer's frame rate is far below the FSM latency).
- `Clear`:
  - Takes priority over every other action in its cycle.
  - Sets FIFO pointers and `count` to 0 and clears `overflow` and `msg_done`.
  - Returns the FSM to IDLE. A `sent` edge detected in the same cycle is discarded.
  - Synchroniser flops are not cleared, so no false edge follows.
- `Reset` low, at any time including mid-frame:
  - All flops cleared and FSM to IDLE.
  - Outputs: `char_out`=0x00, `char_valid`=0, `count`=0, `msg_done`=0, `overflow`=0.

## Timing
- Rising `sent` at the pin to edge detect: SYNC_STAGES+1 cycles.
- Edge detect to character at `char_out` with `char_valid`=1: 3 cycles (CAPTURE, DECODE, PUSH). That is 6 cycles total at default SYNC_STAGES.
- `msg_done` rises 1 cycle after the PUSH, or 2 cycles after CAPTURE when nothing is pushed.
- Pop takes effect at the next edge. `char_out` shows the next entry 1 cycle after the accepting edge.
- `count` updates on the same edge as push/pop.
- Pointers wrap modulo DEPTH. An extra MSB distinguishes full from empty.

## Structure
- Shared package/include `morse_pkg`:
  - Symbol codes SYM_EMPTY/SYM_DOT/SYM_DASH/SYM_ILL.
  - ASCII_SPACE, ASCII_UNKNOWN.
  - FSM state encodings.
  - The producer uses the same symbol codes.
- One sub-module, `morse_char_lut`: combinational, `inbits`[9:0] → {valid_char, is_gap, ascii[7:0]}.
- FIFO and FSM stay inline.

## Test plan
- Frame 0x009 (dot,dash), `spa_end`=0, `sent` pulse, `char_ready`=1 → `char_out`=0x41 ('A') 6 cycles after `sent` rises; `count` returns to 0; `msg_done`=0.
- Frames 0x015 ('S'), 0x2AA ('0'), then 0x000 with `spa_end`=1 → FIFO holds 0x53, 0x30 in order; no third entry; `msg_done`=1.
- Frame 0x003 (illegal) and frame 0x011 (gap inside pattern) → each gives 0x3F; frame 0x000 with `spa_end`=0 → 0x20.
- `char_ready`=0, 17 valid frames → `count`=16, `overflow`=1, first 16 characters read back intact; `Clear` → `count`=0, `overflow`=0, `char_valid`=0.
- FIFO full, push and pop in the same cycle → `count` stays 16, `overflow` stays 0, order preserved.
- `Reset` asserted between CAPTURE and PUSH → all outputs 0 immediately; after release the next frame decodes normally.
